mips_muldiv_unit: RTL and testbench
===================================

Name: mips_muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit with architectural HI/LO registers.
- Sits in the EX stage of the pipelined MIPS core and replaces the single-cycle HI/LO path.
- Executes MULTU/DIVU, plus MULT/DIV when the optional signed feature is built in, and MTHI/MTLO writes.
- Raises a stall to the hazard logic while a result is pending and a younger instruction needs HI/LO or the unit.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits. Must be at least 4.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  EX-stage request; `op` is valid this cycle
- op  input  3  000 none, 001 MULTU, 010 DIVU, 011 MULT, 100 DIV, 101 MTHI, 110 MTLO, 111 reserved (treated as none)
- a  input  WIDTH  rs operand (multiplicand/dividend; data for MTHI/MTLO)
- b  input  WIDTH  rt operand (multiplier/divisor)
- flush  input  1  abort in-flight operation (branch/exception squash)
- rd_hilo  input  1  younger instruction (MFHI/MFLO) reads HI/LO this cycle
- hilo_sel  input  1  1 selects HI, 0 selects LO onto `hilo_out`
- hilo_out  output  WIDTH  combinational mux of the `hi`/`lo` registers
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register
- busy  output  1  arithmetic operation in flight
- done  output  1  one-cycle pulse: HI/LO updated by an arithmetic op
- stall  output  1  pipeline must hold EX and earlier stages
- div_zero  output  1  pulses together with `done` for a divide with b==0

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; `hi`, `lo`, internal accumulators and counter cleared to 0; `busy`, `done`, `div_zero` = 0.
- States and transitions:
  - IDLE -> MUL (op 001/011) or DIV (op 010/100) at the edge where start=1.
  - MUL and DIV each run exactly WIDTH iterations, one per clock, with a counter from WIDTH-1 down to 0.
  - MUL/DIV -> FIN.
  - FIN -> IDLE.
- Multiply: radix-2 shift-add on operand magnitudes. The 2*WIDTH product goes upper half to HI, lower half to LO.
- Divide: restoring, one quotient bit per cycle on magnitudes. Quotient goes to LO, remainder to HI.
- FIN: applies sign fix-up when enabled and writes HI/LO on the FIN edge.
- Latency: start sampled at edge 0; iterations on edges 1..WIDTH; HI/LO written at edge WIDTH+1.
- `done` is high for the cycle following edge WIDTH+1.
- `busy` is high from after edge 0 until edge WIDTH+1, and is low during the `done` cycle.
- A new start is accepted in the `done` cycle, giving back-to-back throughput of WIDTH+2 cycles.
- MTHI/MTLO: accepted only while IDLE. Writes `a` into HI/LO at the next edge; no `busy`, no `done`.
- Start while busy: ignored. `stall`=1 until the unit is idle, then accepted.
- stall = busy & (start | rd_hilo). It is combinational, with no registered delay.
- rd_hilo while idle: no stall; `hilo_out` reflects current registers, including the value written in the `done` cycle.
- Divide by zero (unsigned): LO = all ones, HI = a, div_zero pulses.
- flush: returns the unit to IDLE at the next edge; HI/LO unchanged; no `done`. Flush wins over a simultaneous start. Flush in the FIN cycle still suppresses the HI/LO write.
- Reset mid-operation: operation lost, all registers 0.
- All arithmetic is modulo 2^WIDTH per half; the counter width is clog2(WIDTH).

Optional Feature:
- Macro: MULDIV_SIGNED_EN.
- Defined:
  - op 011/100 take magnitudes of `a` and `b` at start.
  - In FIN, the product is negated (2*WIDTH two's complement) when the signs differ.
  - The quotient is negated when the signs differ; the remainder takes the sign of `a`.
  - Signed divide by zero: `b` is treated as positive, so `a`<0 gives LO=1, HI=a, and `a`>=0 gives LO=all ones, HI=a.
  - MIN/-1 gives LO=MIN, HI=0.
- Undefined:
  - op 011/100 are treated as 001/010 (unsigned), with identical timing.
  - No sign logic is synthesised.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0x2 -> after WIDTH+1 edges HI=0x00000001, LO=0xFFFFFFFE; `done` high exactly one cycle; `busy` high 33 cycles.
- DIVU a=100, b=7 -> LO=14, HI=2. DIVU a=5, b=0 -> LO=0xFFFFFFFF, HI=5, `div_zero`=1 with `done`.
- With MULDIV_SIGNED_EN:
  - MULT -3*5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
  - DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- rd_hilo and a second start asserted 5 cycles into a MULTU -> `stall`=1 until the `done` cycle; second op starts in the `done` cycle; MFHI in the `done` cycle returns the new HI.
- MTHI 0x1234 then flush 10 cycles into a DIVU -> HI stays 0x1234, no `done`, `busy` low next cycle; flush+start same cycle -> stays IDLE.
- rst driven low mid-MULT (cycle 12) -> immediately `busy`=0, `hi`=`lo`=0; after release, MTLO 0xA5 -> LO=0xA5 next edge.

Source files
------------

// File: rtl/mips_muldiv_unit.sv
// Iterative MULTU/DIVU (+MULT/DIV when MULDIV_SIGNED_EN is defined) with HI/LO and MTHI/MTLO.
// Latency: start at edge 0, WIDTH iterations, HI/LO written at edge WIDTH+1, done the cycle after.
// Backpressure: starts while busy are ignored; stall = busy & (start | rd_hilo) holds the pipe.
module mips_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             rd_hilo,
  input  logic             hilo_sel,
  output logic [WIDTH-1:0] hilo_out,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIVU  = 3'b010;
  localparam logic [2:0] OP_MULT  = 3'b011;
  localparam logic [2:0] OP_DIV   = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIN
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             is_div_q, is_div_d;
  logic             divz_q, divz_d;
  logic             done_q, done_d;
  logic             div_zero_q, div_zero_d;

  logic             op_mul, op_div;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift, div_trial;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

`ifdef MULDIV_SIGNED_EN
  logic sgn_op, neg_a, neg_b;
  logic neg_q, neg_d;
  logic a_neg_q, a_neg_d;

  always_comb begin
    sgn_op = (op == OP_MULT) || (op == OP_DIV);
    neg_a  = sgn_op & a[WIDTH-1];
    neg_b  = sgn_op & b[WIDTH-1];
    a_mag  = neg_a ? -a : a;
    b_mag  = neg_b ? -b : b;
  end

  // Quotient/product negate when signs differ; remainder follows the dividend.
  always_comb begin
    prod_fix = neg_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
    quo_fix  = neg_q ? -acc_lo_q : acc_lo_q;
    rem_fix  = a_neg_q ? -acc_hi_q : acc_hi_q;
  end
`else
  always_comb begin
    a_mag    = a;
    b_mag    = b;
    prod_fix = {acc_hi_q, acc_lo_q};
    quo_fix  = acc_lo_q;
    rem_fix  = acc_hi_q;
  end
`endif

  always_comb begin
    op_mul    = (op == OP_MULTU) || (op == OP_MULT);
    op_div    = (op == OP_DIVU) || (op == OP_DIV);
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, dvsr_q} : {(WIDTH+1){1'b0}});
    div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, dvsr_q};
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    dvsr_d     = dvsr_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    is_div_d   = is_div_q;
    divz_d     = divz_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;
`ifdef MULDIV_SIGNED_EN
    neg_d      = neg_q;
    a_neg_d    = a_neg_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          if (op_mul || op_div) begin
            state_d  = op_mul ? S_MUL : S_DIV;
            cnt_d    = CNT_INIT;
            acc_hi_d = '0;
            acc_lo_d = a_mag;
            dvsr_d   = b_mag;
            is_div_d = op_div;
            divz_d   = op_div && (b == '0);
`ifdef MULDIV_SIGNED_EN
            neg_d    = neg_a ^ neg_b;
            a_neg_d  = neg_a;
`endif
          end else if (op == OP_MTHI) begin
            hi_d = a;
          end else if (op == OP_MTLO) begin
            lo_d = a;
          end
        end
      end
      S_MUL: begin
        // {acc_hi, acc_lo} shifts right; acc_lo holds the remaining multiplier bits.
        {acc_hi_d, acc_lo_d} = {mul_sum, acc_lo_q[WIDTH-1:1]};
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == '0) state_d = S_FIN;
      end
      S_DIV: begin
        // acc_hi is the partial remainder; quotient bits shift into acc_lo.
        if (!div_trial[WIDTH]) begin
          acc_hi_d = div_trial[WIDTH-1:0];
          acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_hi_d = div_shift[WIDTH-1:0];
          acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == '0) state_d = S_FIN;
      end
      S_FIN: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        done_d     = 1'b1;
        div_zero_d = divz_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      state_d    = S_IDLE;
      hi_d       = hi_q;
      lo_d       = lo_q;
      done_d     = 1'b0;
      div_zero_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      dvsr_q     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      is_div_q   <= 1'b0;
      divz_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      neg_q      <= 1'b0;
      a_neg_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      dvsr_q     <= dvsr_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      is_div_q   <= is_div_d;
      divz_q     <= divz_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
`ifdef MULDIV_SIGNED_EN
      neg_q      <= neg_d;
      a_neg_q    <= a_neg_d;
`endif
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign stall    = busy & (start | rd_hilo);
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign hilo_out = hilo_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Scoreboard bench for mips_muldiv_unit: stimulus pushes reference results, a monitor checks each done pulse.
module tb_mips_muldiv_unit;

  logic        clk, rst, start, flush, rd_hilo, hilo_sel;
  logic [2:0]  op;
  logic [31:0] a, b, hilo_out, hi, lo;
  logic        busy, done, stall, div_zero;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_bad = 0;

  mips_muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .rd_hilo(rd_hilo), .hilo_sel(hilo_sel),
    .hilo_out(hilo_out), .hi(hi), .lo(lo), .busy(busy), .done(done),
    .stall(stall), .div_zero(div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_vec++;
    n_bad++;
    $display("FAIL %s: timeout waiting for DUT", nm);
  endtask

  // Reference: plain integer arithmetic on the architectural operands.
  function automatic exp_t model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t r;
    bit sgn;
    longint unsigned p;
    longint sp;
    int sx, sy;
`ifdef MULDIV_SIGNED_EN
    sgn = (o == 3'b011) || (o == 3'b100);
`else
    sgn = 1'b0;
`endif
    r = '0;
    if (o == 3'b001 || o == 3'b011) begin
      if (sgn) begin
        sp = longint'($signed(x)) * longint'($signed(y));
        p  = sp;
      end else begin
        p = {32'b0, x} * {32'b0, y};
      end
      r.hi = p[63:32];
      r.lo = p[31:0];
    end else begin
      r.dz = (y == 0);
      sx = $signed(x);
      sy = $signed(y);
      if (!sgn) begin
        if (y == 0) begin r.lo = 32'hFFFFFFFF; r.hi = x; end
        else begin r.lo = x / y; r.hi = x % y; end
      end else if (y == 0) begin
        r.lo = (sx < 0) ? 32'h1 : 32'hFFFFFFFF;
        r.hi = x;
      end else if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin
        r.lo = x;
        r.hi = 0;
      end else begin
        r.lo = sx / sy;
        r.hi = sx % sy;
      end
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst && done) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 expected no done");
      end else begin
        mon_e = sb.pop_front();
        chk("hi", {32'b0, hi}, {32'b0, mon_e.hi});
        chk("lo", {32'b0, lo}, {32'b0, mon_e.lo});
        chk("div_zero", {63'b0, div_zero}, {63'b0, mon_e.dz});
        chk("hilo_out", {32'b0, hilo_out}, {32'b0, hilo_sel ? mon_e.hi : mon_e.lo});
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input bit arith);
    int n = 0;
    while (busy && n < 200) begin @(posedge clk); #1; n++; end
    if (busy) fail_now("issue_wait_idle");
    start = 1'b1; op = o; a = x; b = y;
    if (arith) sb.push_back(model(o, x, y));
    @(posedge clk); #1;
    start = 1'b0; op = 3'b000;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
    if (sb.size() != 0) begin
      fail_now("drain");
      sb.delete();
    end
  endtask

  initial begin
    int busy_cnt, n, dcnt;
    bit got;
    exp_t e1;
    logic [2:0] o;
    logic [31:0] x, y;

    rst = 1'b0; start = 1'b0; op = 3'b000; a = '0; b = '0;
    flush = 1'b0; rd_hilo = 1'b0; hilo_sel = 1'b0;
    #12;
    chk("rst_hi", {32'b0, hi}, 64'h0);
    chk("rst_lo", {32'b0, lo}, 64'h0);
    chk("rst_busy", {63'b0, busy}, 64'h0);
    chk("rst_done", {63'b0, done}, 64'h0);
    chk("rst_div_zero", {63'b0, div_zero}, 64'h0);
    @(posedge clk); #1;
    rst = 1'b1;

    rd_hilo = 1'b1; #1;
    chk("idle_rd_no_stall", {63'b0, stall}, 64'h0);
    rd_hilo = 1'b0;

    // MULTU with busy/done pulse-width measurement
    issue(3'b001, 32'hFFFFFFFF, 32'h2, 1);
    busy_cnt = 0; n = 0; got = 0;
    while (!got && n < 100) begin
      @(negedge clk); n++;
      if (done) got = 1;
      else if (busy) busy_cnt++;
    end
    if (!got) fail_now("multu_done");
    chk("busy_cycles", busy_cnt, 33);
    chk("busy_low_in_done", {63'b0, busy}, 64'h0);
    @(negedge clk);
    chk("done_one_cycle", {63'b0, done}, 64'h0);

    hilo_sel = 1'b1;
    issue(3'b010, 32'd100, 32'd7, 1);
    issue(3'b010, 32'd5, 32'd0, 1);
    hilo_sel = 1'b0;
    issue(3'b011, 32'hFFFFFFFD, 32'd5, 1);
    issue(3'b100, 32'hFFFFFFF9, 32'd2, 1);
    issue(3'b100, 32'h80000000, 32'hFFFFFFFF, 1);
    issue(3'b100, 32'hFFFFFFF0, 32'd0, 1);
    drain();

    // Younger MFHI and second start arrive while a MULTU is in flight
    issue(3'b001, 32'h12345678, 32'h9ABCDEF0, 1);
    e1 = model(3'b001, 32'h12345678, 32'h9ABCDEF0);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; op = 3'b010; a = 32'd1000; b = 32'd33;
    rd_hilo = 1'b1; hilo_sel = 1'b1;
    n = 0; got = 0;
    while (!got && n < 100) begin
      @(negedge clk); n++;
      if (done) begin
        got = 1;
        chk("stall_done_cycle", {63'b0, stall}, 64'h0);
        chk("mfhi_done_cycle", {32'b0, hilo_out}, {32'b0, e1.hi});
      end else begin
        chk("stall_while_busy", {63'b0, stall}, 64'h1);
      end
    end
    if (!got) fail_now("b2b_done");
    sb.push_back(model(3'b010, 32'd1000, 32'd33));
    @(posedge clk); #1;
    start = 1'b0; op = 3'b000; rd_hilo = 1'b0;
    chk("second_op_accepted", {63'b0, busy}, 64'h1);
    drain();

    // MTHI then flushed DIVU
    issue(3'b101, 32'h1234, 32'h0, 0);
    @(negedge clk);
    chk("mthi", {32'b0, hi}, 64'h1234);
    chk("mthi_no_busy", {63'b0, busy}, 64'h0);
    issue(3'b010, 32'd1000, 32'd3, 0);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_busy_low", {63'b0, busy}, 64'h0);
    chk("flush_hi_kept", {32'b0, hi}, 64'h1234);
    dcnt = 0;
    repeat (40) begin @(negedge clk); if (done) dcnt++; end
    chk("flush_no_done", dcnt, 0);
    #1;
    flush = 1'b1; start = 1'b1; op = 3'b001; a = 32'd3; b = 32'd4;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0; op = 3'b000;
    chk("flush_beats_start", {63'b0, busy}, 64'h0);

    // Reset in the middle of a MULT
    issue(3'b011, 32'hDEADBEEF, 32'h00C0FFEE, 0);
    repeat (11) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("midrst_busy", {63'b0, busy}, 64'h0);
    chk("midrst_hi", {32'b0, hi}, 64'h0);
    chk("midrst_lo", {32'b0, lo}, 64'h0);
    @(posedge clk); #1 rst = 1'b1;
    issue(3'b110, 32'hA5, 32'h0, 0);
    chk("mtlo_after_rst", {32'b0, lo}, 64'hA5);
    chk("hi_after_rst", {32'b0, hi}, 64'h0);

    // Randomised mix, issued as soon as the unit is idle (often in the done cycle)
    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom_range(1, 6));
      case ($urandom_range(0, 5))
        0: x = 32'h80000000;
        1: x = $urandom_range(0, 100);
        default: x = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: y = 32'h0;
        1: y = $urandom_range(1, 15);
        2: y = 32'hFFFFFFFF;
        3: y = 32'h80000000;
        default: y = $urandom;
      endcase
      hilo_sel = 1'($urandom_range(0, 1));
      if (o == 3'b101 || o == 3'b110) begin
        issue(o, x, y, 0);
        chk("rand_mt", {32'b0, (o == 3'b101) ? hi : lo}, {32'b0, x});
      end else begin
        issue(o, x, y, 1);
      end
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) @(posedge clk);
      #1;
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
